lcd_cmd_sequencer: RTL

//  Host-side command scheduler for the LCD image-processing core (8x8 pixel cache).

---
 rtl/lcd_cmd_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sequencer.sv
// Host-side command scheduler for the LCD image core: queues host commands, waits out the
// post-reset image load, strobes each command to the idle core and watches WRITE completion.
module lcd_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   lcd_busy,
  input  logic                   lcd_done,
  output logic [2:0]             lcd_cmd,
  output logic                   lcd_cmd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             issued_cnt,
  output logic                   seq_idle,
  output logic                   err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ISSUE,
    GAP,
    WAIT_WR,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            valid_q, valid_d;
  logic [7:0]      issued_q, issued_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push, pop;

  assign host_ready    = (count_q != C_FULL);
  assign push          = host_valid && host_ready;
  assign seq_idle      = (state_q == IDLE) && (count_q == '0);
  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = valid_q;
  assign fifo_count    = count_q;
  assign issued_cnt    = issued_q;
  assign err_timeout   = err_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    valid_d  = 1'b0;
    issued_d = issued_q;
    err_d    = err_q;
    timer_d  = timer_q;
    pop      = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (!lcd_busy) state_d = IDLE;
      end
      IDLE: begin
        if ((count_q != '0) && !lcd_busy) begin
          pop      = 1'b1;
          cmd_d    = mem[rd_ptr_q];
          valid_d  = 1'b1;
          issued_d = issued_q + 8'd1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = (cmd_q == 3'd0) ? WAIT_WR : GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      WAIT_WR: begin
        // A done on the final allowed cycle still counts as on time.
        if (lcd_done) begin
          state_d = IDLE;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr_q] <= host_cmd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= BOOT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= 3'd0;
      valid_q  <= 1'b0;
      issued_q <= 8'd0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

endmodule
